// File: rtl/cam_pkg.sv
// cam_pkg: shared types, default geometry and RGB332 helpers for the camera capture path
package cam_pkg;
   localparam int DEF_SCREEN_WIDTH  = 176;
   localparam int DEF_SCREEN_HEIGHT = 144;
   localparam int DEF_ADDR_WIDTH    = 15;
   typedef enum logic [1:0] {IDLE, FRAME, LINE, DONE} state_t;
   localparam logic [7:0] RED   = 8'hE0;
   localparam logic [7:0] GREEN = 8'h1C;
   localparam logic [7:0] BLUE  = 8'h03;
   localparam logic [7:0] WHITE = 8'hFF;
   function automatic logic [7:0] rgb332(input logic [2:0] r, input logic [2:0] g, input logic [1:0] b);
      return {r, g, b};
   endfunction
endpackage

// File: rtl/camera_capture_ctrl_pixel_packer.sv
// camera_capture_ctrl_pixel_packer: pairs the two RGB444 camera bytes of a pixel into one RGB332 word
module camera_capture_ctrl_pixel_packer
   import cam_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_valid,
   input  logic [7:0] d,
   output logic       pixel_valid,
   output logic [7:0] pixel
);
   logic       phase;
   logic [2:0] r_q;
   logic       unused_bits;
   // phase toggles per accepted byte; any gap in valid bytes drops a dangling half-pixel
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         phase <= 1'b0;
         r_q   <= '0;
      end else if (!byte_valid) begin
         phase <= 1'b0;
      end else begin
         phase <= ~phase;
         if (!phase) r_q <= d[3:1];
      end
   assign pixel_valid = byte_valid & phase;
   assign pixel       = rgb332(r_q, d[7:5], d[3:2]);
   assign unused_bits = ^{d[4], d[0]};
endmodule

// File: rtl/camera_capture_ctrl.sv
// camera_capture_ctrl: VSYNC/HREF framing, pixel addressing and status for the camera-to-frame-buffer write port
module camera_capture_ctrl
   import cam_pkg::*;
#(
   parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
   parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  CAPTURE_EN,
   input  logic                  VSYNC,
   input  logic                  HREF,
   input  logic [7:0]            DATA,
   output logic                  W_EN,
   output logic [ADDR_WIDTH-1:0] W_ADDR,
   output logic [7:0]            W_DATA,
   output logic                  FRAME_DONE,
   output logic                  BUSY,
   output logic [7:0]            FRAME_COUNT,
   output logic                  ERR
);
   localparam int XW = $clog2(SCREEN_WIDTH + 1);
   localparam int YW = $clog2(SCREEN_HEIGHT);
   state_t                state;
   logic                  vs_q, vs_qq, hr_q, hr_qq;
   logic [7:0]            d_q;
   logic [XW-1:0]         x;
   logic [YW-1:0]         y;
   logic [ADDR_WIDTH-1:0] line_base;
   logic                  vs_rise, hr_rise, hr_fall, byte_valid, pixel_valid;
   logic [7:0]            pixel;
   // register camera pins once, keep a second copy for edge detection
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         {vs_q, vs_qq, hr_q, hr_qq} <= '0;
         d_q <= '0;
      end else begin
         vs_q  <= VSYNC;
         vs_qq <= vs_q;
         hr_q  <= HREF;
         hr_qq <= hr_q;
         d_q   <= DATA;
      end
   // edges and byte acceptance; a line starting together with VSYNC is ignored
   always_comb begin
      vs_rise    = vs_q & ~vs_qq;
      hr_rise    = hr_q & ~hr_qq;
      hr_fall    = ~hr_q & hr_qq;
      byte_valid = hr_q & ~vs_rise & (state == LINE || (state == FRAME && hr_rise));
   end
   camera_capture_ctrl_pixel_packer u_pack (
      .clk        (CLK),
      .rst        (RESET),
      .byte_valid (byte_valid),
      .d          (d_q),
      .pixel_valid(pixel_valid),
      .pixel      (pixel)
   );
   // frame/line sequencer with registered write port and status outputs
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         state       <= IDLE;
         x           <= '0;
         y           <= '0;
         line_base   <= '0;
         W_EN        <= 1'b0;
         W_ADDR      <= '0;
         W_DATA      <= '0;
         FRAME_DONE  <= 1'b0;
         BUSY        <= 1'b0;
         FRAME_COUNT <= '0;
         ERR         <= 1'b0;
      end else begin
         W_EN       <= 1'b0;
         FRAME_DONE <= 1'b0;
         case (state)
            IDLE:
               if (vs_rise && CAPTURE_EN) begin
                  state     <= FRAME;
                  BUSY      <= 1'b1;
                  x         <= '0;
                  y         <= '0;
                  line_base <= '0;
               end
            FRAME, LINE:
               if (vs_rise) begin
                  ERR       <= 1'b1;
                  state     <= CAPTURE_EN ? FRAME : IDLE;
                  BUSY      <= CAPTURE_EN;
                  x         <= '0;
                  y         <= '0;
                  line_base <= '0;
               end else if (state == FRAME) begin
                  if (hr_rise) state <= LINE;
               end else if (hr_fall) begin
                  x <= '0;
                  if (y == YW'(SCREEN_HEIGHT - 1)) begin
                     state       <= DONE;
                     BUSY        <= 1'b0;
                     FRAME_DONE  <= 1'b1;
                     FRAME_COUNT <= FRAME_COUNT + 8'd1;
                  end else begin
                     y         <= y + 1'b1;
                     line_base <= line_base + ADDR_WIDTH'(SCREEN_WIDTH);
                     state     <= FRAME;
                  end
               end else if (pixel_valid) begin
                  if (x < XW'(SCREEN_WIDTH)) begin
                     W_EN   <= 1'b1;
                     W_ADDR <= line_base + ADDR_WIDTH'(x);
                     W_DATA <= pixel;
                     x      <= x + 1'b1;
                  end else begin
                     ERR <= 1'b1;
                  end
               end
            DONE: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_camera_capture_ctrl.sv
// tb_camera_capture_ctrl: directed self-checking bench for camera_capture_ctrl
module tb_camera_capture_ctrl;
   import cam_pkg::*;
   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        CAPTURE_EN = 1'b0;
   logic        VSYNC = 1'b0;
   logic        HREF = 1'b0;
   logic [7:0]  DATA = '0;
   logic        W_EN;
   logic [14:0] W_ADDR;
   logic [7:0]  W_DATA;
   logic        FRAME_DONE;
   logic        BUSY;
   logic [7:0]  FRAME_COUNT;
   logic        ERR;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [14:0] wq[$];
   logic [7:0]  dq[$];
   int          done_cnt = 0;
   int          en_runs = 0;
   logic        en_prev = 1'b0;
   logic        busy_seen = 1'b0;

   camera_capture_ctrl dut (
      .CLK(CLK), .RESET(RESET), .CAPTURE_EN(CAPTURE_EN), .VSYNC(VSYNC), .HREF(HREF), .DATA(DATA),
      .W_EN(W_EN), .W_ADDR(W_ADDR), .W_DATA(W_DATA), .FRAME_DONE(FRAME_DONE), .BUSY(BUSY),
      .FRAME_COUNT(FRAME_COUNT), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_px(input int p);
      logic [7:0] b0, b1;
      b0 = 8'(p);
      b1 = 8'(p * 3);
      return {b0[3:1], b1[7:5], b1[3:2]};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic vsync_pulse();
      VSYNC = 1'b1;
      tick(2);
      VSYNC = 1'b0;
      tick(2);
   endtask

   task automatic send_line(input int nbytes);
      HREF = 1'b1;
      for (int i = 0; i < nbytes; i++) begin
         DATA = (i % 2 == 0) ? 8'(i / 2) : 8'((i / 2) * 3);
         tick(1);
      end
      HREF = 1'b0;
      DATA = '0;
      tick(3);
   endtask

   task automatic send_lines(input int nlines, input int nbytes);
      for (int l = 0; l < nlines; l++) send_line(nbytes);
   endtask

   task automatic clear_log();
      wq.delete();
      dq.delete();
   endtask

   always @(negedge CLK) begin
      if (W_EN) begin
         wq.push_back(W_ADDR);
         dq.push_back(W_DATA);
         if (en_prev) en_runs++;
      end
      en_prev = W_EN;
      if (FRAME_DONE) done_cnt++;
      if (BUSY) busy_seen = 1'b1;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base, d0, bad_a, bad_d;
      tick(2);
      check("rst_w_en", 32'(W_EN), 0);
      check("rst_w_addr", 32'(W_ADDR), 0);
      check("rst_w_data", 32'(W_DATA), 0);
      check("rst_done", 32'(FRAME_DONE), 0);
      check("rst_busy", 32'(BUSY), 0);
      check("rst_count", 32'(FRAME_COUNT), 0);
      check("rst_err", 32'(ERR), 0);
      RESET = 1'b0;
      tick(2);

      CAPTURE_EN = 1'b1;
      vsync_pulse();
      check("busy_frame", 32'(BUSY), 1);
      HREF = 1'b1; DATA = 8'h0A; tick(1);
      DATA = 8'hA4; tick(1);
      check("pack0_early", 32'(W_EN), 0);
      DATA = 8'h0E; tick(1);
      check("pack0_en", 32'(W_EN), 1);
      check("pack0_data", 32'(W_DATA), 32'h0B5);
      check("pack0_addr", 32'(W_ADDR), 0);
      DATA = 8'hEC; tick(1);
      check("pack0_one_cycle", 32'(W_EN), 0);
      HREF = 1'b0; DATA = '0; tick(1);
      check("pack1_en", 32'(W_EN), 1);
      check("pack1_data", 32'(W_DATA), 32'(WHITE));
      check("pack1_addr", 32'(W_ADDR), 1);
      tick(3);

      HREF = 1'b1;
      for (int i = 0; i < 80; i++) begin
         DATA = 8'(i);
         tick(1);
      end
      #2 RESET = 1'b1;
      #1;
      check("arst_w_en", 32'(W_EN), 0);
      check("arst_w_addr", 32'(W_ADDR), 0);
      check("arst_w_data", 32'(W_DATA), 0);
      check("arst_busy", 32'(BUSY), 0);
      check("arst_err", 32'(ERR), 0);
      tick(1);
      RESET = 1'b0;
      base = wq.size();
      busy_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         DATA = 8'(i);
         tick(1);
      end
      HREF = 1'b0;
      tick(3);
      send_lines(3, 10);
      check("rst_no_writes", 32'(wq.size() - base), 0);
      check("rst_no_busy", 32'(busy_seen), 0);

      clear_log();
      en_runs = 0;
      d0 = done_cnt;
      vsync_pulse();
      send_lines(144, 352);
      bad_a = 0;
      bad_d = 0;
      foreach (wq[i]) begin
         if (32'(wq[i]) != i) bad_a++;
         if (dq[i] !== exp_px(int'(wq[i]) % 176)) bad_d++;
      end
      check("full_writes", 32'(wq.size()), 25344);
      check("full_addr_bad", 32'(bad_a), 0);
      check("full_data_bad", 32'(bad_d), 0);
      check("full_done", 32'(done_cnt - d0), 1);
      check("full_count", 32'(FRAME_COUNT), 1);
      check("full_err", 32'(ERR), 0);
      check("full_busy_idle", 32'(BUSY), 0);
      check("full_en_runs", 32'(en_runs), 0);

      clear_log();
      vsync_pulse();
      send_line(360);
      send_line(4);
      check("long_writes", 32'(wq.size()), 178);
      check("long_last_addr", 32'(wq[175]), 175);
      check("long_last_data", 32'(dq[175]), 32'(exp_px(175)));
      check("long_next_line", 32'(wq[176]), 176);
      check("long_err", 32'(ERR), 1);

      RESET = 1'b1; tick(1); RESET = 1'b0; tick(1);
      d0 = done_cnt;
      vsync_pulse();
      send_lines(10, 2);
      check("short_err_before", 32'(ERR), 0);
      vsync_pulse();
      check("short_err", 32'(ERR), 1);
      check("short_done", 32'(done_cnt - d0), 0);
      check("short_count", 32'(FRAME_COUNT), 0);
      check("short_restart_busy", 32'(BUSY), 1);
      clear_log();
      send_lines(144, 2);
      check("after_short_writes", 32'(wq.size()), 144);
      check("after_short_first", 32'(wq[0]), 0);
      check("after_short_last", 32'(wq[143]), 25168);
      check("after_short_done", 32'(done_cnt - d0), 1);
      check("after_short_count", 32'(FRAME_COUNT), 1);

      CAPTURE_EN = 1'b0;
      tick(2);
      clear_log();
      busy_seen = 1'b0;
      d0 = done_cnt;
      vsync_pulse();
      send_lines(144, 2);
      check("dis_writes", 32'(wq.size()), 0);
      check("dis_busy", 32'(busy_seen), 0);
      check("dis_done", 32'(done_cnt - d0), 0);
      CAPTURE_EN = 1'b1;
      vsync_pulse();
      send_lines(50, 2);
      CAPTURE_EN = 1'b0;
      send_lines(94, 2);
      check("drop_writes", 32'(wq.size()), 144);
      check("drop_done", 32'(done_cnt - d0), 1);
      check("drop_count", 32'(FRAME_COUNT), 2);

      CAPTURE_EN = 1'b1;
      vsync_pulse();
      clear_log();
      send_line(5);
      send_line(2);
      check("odd_writes", 32'(wq.size()), 3);
      check("odd_last_addr", 32'(wq[1]), 1);
      check("odd_next_addr", 32'(wq[2]), 176);
      check("odd_next_data", 32'(dq[2]), 32'(exp_px(0)));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
